// File: rtl/doled_strip_pkg.sv
// Shared constants, state encoding and helpers for the doled strip driver.
package doled_pkg;

  localparam logic [7:0] START_FRAME_BYTE = 8'h00;
  localparam logic [7:0] END_FRAME_BYTE   = 8'hFF;
  localparam logic [2:0] HDR_PREFIX       = 3'b111;

  localparam logic [1:0] ORDER_BGR = 2'd0;
  localparam logic [1:0] ORDER_RGB = 2'd1;
  localparam logic [1:0] ORDER_GRB = 2'd2;

  // Frame sequencer states (plain constants so legacy code can compare against them)
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_SOF   = 3'd1;
  localparam logic [2:0] ST_FETCH = 3'd2;
  localparam logic [2:0] ST_HDR   = 3'd3;
  localparam logic [2:0] ST_C0    = 3'd4;
  localparam logic [2:0] ST_C1    = 3'd5;
  localparam logic [2:0] ST_C2    = 3'd6;
  localparam logic [2:0] ST_EOF   = 3'd7;

  typedef struct packed {
    logic [7:0] blue;
    logic [7:0] green;
    logic [7:0] red;
  } pixel_t;

  // End frame must supply at least one clock edge per two LEDs, never fewer than 4 bytes
  function automatic int end_bytes_for(input int num_leds);
    int n;
    n = (num_leds + 15) / 16;
    return (n < 4) ? 4 : n;
  endfunction

  // Colour byte for slot 0..2 of an LED frame under the given byte order
  function automatic logic [7:0] color_byte(input logic [1:0] order, input logic [1:0] slot,
                                            input pixel_t px);
    logic [7:0] b;
    b = px.red;
    case (order)
      ORDER_RGB: b = (slot == 2'd0) ? px.red   : (slot == 2'd1) ? px.green : px.blue;
      ORDER_GRB: b = (slot == 2'd0) ? px.green : (slot == 2'd1) ? px.red   : px.blue;
      ORDER_BGR: b = (slot == 2'd0) ? px.blue  : (slot == 2'd1) ? px.green : px.red;
      default:   b = (slot == 2'd0) ? px.blue  : (slot == 2'd1) ? px.green : px.red;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/doled_strip_if.sv
// Pixel-store fetch bus: the strip driver is master, the pixel store is slave.
interface doled_strip_if;
  logic [9:0] pix_index;
  logic       pix_req;
  logic       pix_valid;
  logic [7:0] pix_blue;
  logic [7:0] pix_green;
  logic [7:0] pix_red;

  modport master (
    output pix_index, pix_req,
    input  pix_valid, pix_blue, pix_green, pix_red
  );

  modport slave (
    input  pix_index, pix_req,
    output pix_valid, pix_blue, pix_green, pix_red
  );
endinterface

// File: rtl/doled_strip_shift.sv
// Byte serialiser: MSB first, SCK idles low, CLK_DIV cycles per SCK half-period.
module doled_shift #(
  parameter int CLK_DIV = 2
) (
  input  logic       doled_clk,
  input  logic       doled_reset,
  input  logic       load,
  input  logic [7:0] data,
  output logic       busy,
  output logic       mosi,
  output logic       sck
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);

  logic [7:0]       shift_reg;
  logic [2:0]       bit_cnt_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             busy_reg;
  logic             mosi_reg;
  logic             sck_reg;

  // Load a byte when idle, then walk low/high half-periods for each of the 8 bits
  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_cnt_reg <= '0;
      busy_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      sck_reg     <= 1'b0;
    end else if (!busy_reg) begin
      if (load) begin
        shift_reg   <= data;
        mosi_reg    <= data[7];
        bit_cnt_reg <= '0;
        div_cnt_reg <= '0;
        sck_reg     <= 1'b0;
        busy_reg    <= 1'b1;
      end
    end else if (div_cnt_reg == DIV_MAX) begin
      div_cnt_reg <= '0;
      if (!sck_reg) begin
        sck_reg <= 1'b1;
      end else begin
        sck_reg <= 1'b0;
        if (bit_cnt_reg == 3'd7) begin
          // mosi keeps the last bit through the inter-byte gap
          busy_reg <= 1'b0;
        end else begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
          shift_reg   <= {shift_reg[6:0], 1'b0};
          mosi_reg    <= shift_reg[6];
        end
      end
    end else begin
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
    end
  end

  assign busy = busy_reg;
  assign mosi = mosi_reg;
  assign sck  = sck_reg;

endmodule

// File: rtl/doled_strip.sv
// Frame-level APA102 strip driver: start frame, per-LED fetch + 4 bytes, end frame.
module doled_strip
  import doled_pkg::*;
#(
  parameter int NUM_LEDS = 60,
  parameter int CLK_DIV  = 2
) (
  input  logic          doled_clk,
  input  logic          doled_reset,
  input  logic          doled_strip_start,
  output logic          doled_strip_busy,
  output logic          doled_strip_done,
  input  logic [4:0]    brightness,
  input  logic [1:0]    color_order,
  doled_strip_if.master pix,
  output logic          mosi,
  output logic          sck
);

  localparam int END_BYTES = end_bytes_for(NUM_LEDS);
  localparam logic [9:0] LAST_LED = 10'(NUM_LEDS - 1);
  localparam logic [7:0] END_CNT  = 8'(END_BYTES);

  logic [2:0] state_reg,    state_next;
  logic [9:0] led_cnt_reg,  led_cnt_next;
  logic [7:0] byte_cnt_reg, byte_cnt_next;
  logic [4:0] bright_reg,   bright_next;
  logic [1:0] order_reg,    order_next;
  pixel_t     pixel_reg,    pixel_next;
  logic       busy_reg,     busy_next;
  logic       done_reg,     done_next;
  logic       req_reg,      req_next;

  logic       sh_load;
  logic [7:0] sh_data;
  logic       sh_busy;

  doled_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .doled_clk   (doled_clk),
    .doled_reset (doled_reset),
    .load        (sh_load),
    .data        (sh_data),
    .busy        (sh_busy),
    .mosi        (mosi),
    .sck         (sck)
  );

  // Sequencer: each sending state hands one byte to the idle serialiser and moves on
  always_comb begin
    state_next    = state_reg;
    led_cnt_next  = led_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    bright_next   = bright_reg;
    order_next    = order_reg;
    pixel_next    = pixel_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    req_next      = req_reg;
    sh_load       = 1'b0;
    sh_data       = START_FRAME_BYTE;

    case (state_reg)
      ST_IDLE: begin
        if (doled_strip_start) begin
          bright_next   = brightness;
          order_next    = color_order;
          busy_next     = 1'b1;
          byte_cnt_next = '0;
          state_next    = ST_SOF;
        end
      end
      ST_SOF: begin
        sh_data = START_FRAME_BYTE;
        if (!sh_busy) begin
          sh_load = 1'b1;
          if (byte_cnt_reg == 8'd3) begin
            byte_cnt_next = '0;
            led_cnt_next  = '0;
            state_next    = ST_FETCH;
          end else begin
            byte_cnt_next = byte_cnt_reg + 8'd1;
          end
        end
      end
      ST_FETCH: begin
        // Request only once the previous byte has fully left, so sck stays low while stalled
        if (!req_reg) begin
          if (!sh_busy) req_next = 1'b1;
        end else if (pix.pix_valid) begin
          pixel_next = '{blue: pix.pix_blue, green: pix.pix_green, red: pix.pix_red};
          req_next   = 1'b0;
          state_next = ST_HDR;
        end
      end
      ST_HDR: begin
        sh_data = {HDR_PREFIX, bright_reg};
        if (!sh_busy) begin
          sh_load    = 1'b1;
          state_next = ST_C0;
        end
      end
      ST_C0: begin
        sh_data = color_byte(order_reg, 2'd0, pixel_reg);
        if (!sh_busy) begin
          sh_load    = 1'b1;
          state_next = ST_C1;
        end
      end
      ST_C1: begin
        sh_data = color_byte(order_reg, 2'd1, pixel_reg);
        if (!sh_busy) begin
          sh_load    = 1'b1;
          state_next = ST_C2;
        end
      end
      ST_C2: begin
        sh_data = color_byte(order_reg, 2'd2, pixel_reg);
        if (!sh_busy) begin
          sh_load = 1'b1;
          if (led_cnt_reg == LAST_LED) begin
            byte_cnt_next = '0;
            state_next    = ST_EOF;
          end else begin
            led_cnt_next = led_cnt_reg + 10'd1;
            state_next   = ST_FETCH;
          end
        end
      end
      ST_EOF: begin
        sh_data = END_FRAME_BYTE;
        if (byte_cnt_reg < END_CNT) begin
          if (!sh_busy) begin
            sh_load       = 1'b1;
            byte_cnt_next = byte_cnt_reg + 8'd1;
          end
        end else if (!sh_busy) begin
          busy_next  = 1'b0;
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // State registers; reset aborts any frame in progress
  always_ff @(posedge doled_clk or posedge doled_reset) begin
    if (doled_reset) begin
      state_reg    <= ST_IDLE;
      led_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      bright_reg   <= '0;
      order_reg    <= ORDER_BGR;
      pixel_reg    <= '0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      req_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      led_cnt_reg  <= led_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      bright_reg   <= bright_next;
      order_reg    <= order_next;
      pixel_reg    <= pixel_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      req_reg      <= req_next;
    end
  end

  assign doled_strip_busy = busy_reg;
  assign doled_strip_done = done_reg;
  assign pix.pix_req      = req_reg;
  assign pix.pix_index    = led_cnt_reg;

endmodule

// File: tb/tb_doled_strip.sv
// Randomised frame-level bench for doled_strip with a byte-stream reference model.
module tb_doled_strip;

  localparam int NS = 3;
  localparam int NB = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_s, start_b;
  logic [4:0] bright;
  logic [1:0] order;
  logic       busy_s, done_s, mosi_s, sck_s;
  logic       busy_b, done_b, mosi_b, sck_b;

  doled_strip_if pif ();
  doled_strip_if pifb ();

  doled_strip #(.NUM_LEDS(NS), .CLK_DIV(1)) dut (
    .doled_clk(clk), .doled_reset(rst), .doled_strip_start(start_s),
    .doled_strip_busy(busy_s), .doled_strip_done(done_s),
    .brightness(bright), .color_order(order), .pix(pif), .mosi(mosi_s), .sck(sck_s)
  );

  doled_strip #(.NUM_LEDS(NB), .CLK_DIV(2)) dut_big (
    .doled_clk(clk), .doled_reset(rst), .doled_strip_start(start_b),
    .doled_strip_busy(busy_b), .doled_strip_done(done_b),
    .brightness(bright), .color_order(order), .pix(pifb), .mosi(mosi_b), .sck(sck_b)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pixel store contents and per-LED response delays for the small strip
  logic [7:0] px_b [0:NS-1];
  logic [7:0] px_g [0:NS-1];
  logic [7:0] px_r [0:NS-1];
  int         dly  [0:NS-1];

  // Small-strip pixel store: answer after dly cycles, random noise when not requested
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (pif.pix_req) begin
      int i;
      i = (int'(pif.pix_index) < NS) ? int'(pif.pix_index) : 0;
      if (wait_cnt >= dly[i]) begin
        pif.pix_valid = 1'b1;
        pif.pix_blue  = px_b[i];
        pif.pix_green = px_g[i];
        pif.pix_red   = px_r[i];
      end else begin
        pif.pix_valid = 1'b0;
        pif.pix_blue  = 8'($urandom);
        pif.pix_green = 8'($urandom);
        pif.pix_red   = 8'($urandom);
        wait_cnt++;
      end
    end else begin
      wait_cnt      = 0;
      pif.pix_valid = 1'($urandom_range(0, 1));
      pif.pix_blue  = 8'($urandom);
      pif.pix_green = 8'($urandom);
      pif.pix_red   = 8'($urandom);
    end
  end

  // Large-strip pixel store: always answers at once
  always @(negedge clk) begin
    pifb.pix_valid = pifb.pix_req;
    pifb.pix_blue  = pifb.pix_index[7:0];
    pifb.pix_green = ~pifb.pix_index[7:0];
    pifb.pix_red   = 8'(pifb.pix_index + 10'd1);
  end

  // Small-strip monitor: decodes bytes on sck rises, tracks fetches and done pulses
  logic       mon_clr = 1'b0;
  logic [7:0] got_q [$];
  logic [9:0] idx_seq [$];
  int         req_cyc [0:NS-1];
  int         bits, rises, done_cnt;
  logic [7:0] cur;
  logic       sck_prev = 1'b0, req_prev = 1'b0, sck_bad, done_busy_bad;
  always @(negedge clk) begin
    if (mon_clr) begin
      got_q.delete();
      idx_seq.delete();
      for (int i = 0; i < NS; i++) req_cyc[i] = 0;
      bits = 0; rises = 0; done_cnt = 0; cur = 8'h00;
      sck_bad = 1'b0; done_busy_bad = 1'b0; req_prev = 1'b0;
    end else begin
      if (sck_s && !sck_prev) begin
        rises++;
        cur = {cur[6:0], mosi_s};
        bits++;
        if (bits == 8) begin
          got_q.push_back(cur);
          bits = 0;
        end
      end
      if (done_s) begin
        done_cnt++;
        if (busy_s) done_busy_bad = 1'b1;
      end
      if (pif.pix_req) begin
        if (!req_prev) idx_seq.push_back(pif.pix_index);
        if (int'(pif.pix_index) < NS) req_cyc[pif.pix_index]++;
        if (sck_s) sck_bad = 1'b1;
      end
      req_prev = pif.pix_req;
    end
    sck_prev = sck_s;
  end

  // Large-strip monitor: sck rise count, fetch index sequence, done pulses
  logic       mon_clr_b = 1'b0;
  logic [9:0] idx_seq_b [$];
  int         rises_b, done_cnt_b;
  logic       sck_prev_b = 1'b0, req_prev_b = 1'b0;
  always @(negedge clk) begin
    if (mon_clr_b) begin
      idx_seq_b.delete();
      rises_b = 0; done_cnt_b = 0; req_prev_b = 1'b0;
    end else begin
      if (sck_b && !sck_prev_b) rises_b++;
      if (done_b) done_cnt_b++;
      if (pifb.pix_req && !req_prev_b) idx_seq_b.push_back(pifb.pix_index);
      req_prev_b = pifb.pix_req;
    end
    sck_prev_b = sck_b;
  end

  // Reference model: the byte stream a strip of n LEDs must receive
  logic [7:0] exp_q [$];
  function automatic int end_bytes(input int n);
    int e;
    e = (n + 15) / 16;
    return (e < 4) ? 4 : e;
  endfunction

  task automatic build_expected(input logic [4:0] br, input logic [1:0] ord);
    exp_q.delete();
    repeat (4) exp_q.push_back(8'h00);
    for (int i = 0; i < NS; i++) begin
      exp_q.push_back({3'b111, br});
      if (ord == 2'd1) begin
        exp_q.push_back(px_r[i]); exp_q.push_back(px_g[i]); exp_q.push_back(px_b[i]);
      end else if (ord == 2'd2) begin
        exp_q.push_back(px_g[i]); exp_q.push_back(px_r[i]); exp_q.push_back(px_b[i]);
      end else begin
        exp_q.push_back(px_b[i]); exp_q.push_back(px_g[i]); exp_q.push_back(px_r[i]);
      end
    end
    repeat (end_bytes(NS)) exp_q.push_back(8'hFF);
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    #1 mon_clr = 1'b0;
  endtask

  task automatic set_pixels(input bit rnd);
    for (int i = 0; i < NS; i++) begin
      px_b[i] = rnd ? 8'($urandom) : 8'(3 * i + 1);
      px_g[i] = rnd ? 8'($urandom) : 8'(3 * i + 2);
      px_r[i] = rnd ? 8'($urandom) : 8'(3 * i + 3);
      dly[i]  = 0;
    end
  endtask

  task automatic wait_done_small(input int bound, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done_s && n < bound);
    check_eq({tag, "_timeout"}, 32'(n < bound), 32'd1);
  endtask

  // One complete small-strip frame, checked against the reference byte stream
  int frame_no = 0;
  task automatic run_frame(input logic [4:0] br, input logic [1:0] ord,
                           input bit mid_change, input bit extra_start);
    build_expected(br, ord);
    clear_mon();
    @(negedge clk);
    start_s = 1'b1; bright = br; order = ord;
    @(negedge clk);
    start_s = 1'b0;
    check_eq("busy_rise", 32'(busy_s), 32'd1);
    if (mid_change) begin
      bright = 5'h10;
      order  = 2'(ord + 2'd1);
    end
    if (extra_start) begin
      repeat (40) @(negedge clk);
      start_s = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
    end
    wait_done_small(3000, "frame_done");
    repeat (60) @(negedge clk);
    check_eq("byte_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check_eq($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    check_eq("sck_rises", 32'(rises), 32'(8 * exp_q.size()));
    check_eq("done_pulses", 32'(done_cnt), 32'd1);
    check_eq("done_with_busy_low", 32'(done_busy_bad), 32'd0);
    check_eq("sck_low_in_fetch", 32'(sck_bad), 32'd0);
    check_eq("fetch_count", 32'(idx_seq.size()), 32'(NS));
    for (int i = 0; i < NS && i < idx_seq.size(); i++)
      check_eq($sformatf("fetch_index%0d", i), 32'(idx_seq[i]), 32'(i));
    for (int i = 0; i < NS; i++)
      check_eq($sformatf("req_cycles%0d", i), 32'(req_cyc[i]), 32'(dly[i] + 1));
    check_eq("busy_idle", 32'(busy_s), 32'd0);
    $display("frame %0d: order=%0d bright=%02h bytes=%0d rises=%0d dly=%0d/%0d/%0d",
             frame_no, ord, br, got_q.size(), rises, dly[0], dly[1], dly[2]);
    frame_no++;
  endtask

  initial begin
    rst = 1'b1; start_s = 1'b0; start_b = 1'b0; bright = 5'h00; order = 2'd0;
    set_pixels(1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", 32'(busy_s), 32'd0);
    check_eq("rst_done", 32'(done_s), 32'd0);
    check_eq("rst_req", 32'(pif.pix_req), 32'd0);
    check_eq("rst_index", 32'(pif.pix_index), 32'd0);
    check_eq("rst_mosi", 32'(mosi_s), 32'd0);
    check_eq("rst_sck", 32'(sck_s), 32'd0);

    // Reference frame: BGR, full brightness, pixels 01..09
    set_pixels(1'b0);
    run_frame(5'h1F, 2'd0, 1'b0, 1'b0);
    // RGB, brightness 3, brightness/order changed mid-frame
    run_frame(5'h03, 2'd1, 1'b1, 1'b0);
    // Slow pixel store on LED 1
    dly[1] = 7;
    run_frame(5'h0A, 2'd2, 1'b0, 1'b0);
    // Start pulsed again while busy
    dly[1] = 0;
    run_frame(5'h11, 2'd3, 1'b0, 1'b1);

    // Randomised frames
    for (int k = 0; k < 6; k++) begin
      set_pixels(1'b1);
      for (int i = 0; i < NS; i++) dly[i] = int'($urandom_range(0, 4));
      run_frame(5'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'b0);
    end

    // Reset during the second colour byte of LED 1
    begin
      int n;
      set_pixels(1'b0);
      clear_mon();
      @(negedge clk);
      start_s = 1'b1; bright = 5'h1F; order = 2'd0;
      @(negedge clk);
      start_s = 1'b0;
      n = 0;
      while (!(got_q.size() == 10 && bits >= 2) && n < 1000) begin
        @(negedge clk);
        n++;
      end
      check_eq("reach_led1_c1_timeout", 32'(n < 1000), 32'd1);
      #1 rst = 1'b1;
      #1;
      check_eq("abort_sck", 32'(sck_s), 32'd0);
      check_eq("abort_mosi", 32'(mosi_s), 32'd0);
      check_eq("abort_busy", 32'(busy_s), 32'd0);
      check_eq("abort_req", 32'(pif.pix_req), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      $display("reset abort after %0d bytes", got_q.size());
      run_frame(5'h1F, 2'd0, 1'b0, 1'b0);
    end

    // 100-LED strip with CLK_DIV=2
    begin
      int n;
      mon_clr_b = 1'b1;
      @(negedge clk);
      #1 mon_clr_b = 1'b0;
      @(negedge clk);
      start_b = 1'b1; bright = 5'h07; order = 2'd1;
      @(negedge clk);
      start_b = 1'b0;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!done_b && n < 20000);
      check_eq("big_done_timeout", 32'(n < 20000), 32'd1);
      repeat (20) @(negedge clk);
      check_eq("big_sck_rises", 32'(rises_b), 32'(8 * (4 + 4 * NB + end_bytes(NB))));
      check_eq("big_done_pulses", 32'(done_cnt_b), 32'd1);
      check_eq("big_fetch_count", 32'(idx_seq_b.size()), 32'(NB));
      for (int i = 0; i < NB && i < idx_seq_b.size(); i++)
        check_eq($sformatf("big_index%0d", i), 32'(idx_seq_b[i]), 32'(i));
      $display("big frame: rises=%0d fetches=%0d", rises_b, idx_seq_b.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
